// File: rtl/battery_switch_ctrl.sv
// Two-battery source selector with break-before-make dead time and a shared
// charger. The charger only ever serves the battery that is not powering the load.
module battery_switch_ctrl #(
  parameter int WIDTH    = 4,
  parameter int LOW_TH   = 2,
  parameter int DEAD_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] battA,
  input  logic [WIDTH-1:0] battB,
  output logic             sel_a,
  output logic             sel_b,
  output logic             chg_a,
  output logic             chg_b,
  output logic             alarm,
  output logic [7:0]       switch_cnt
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN_A,
    ST_RUN_B,
    ST_DEAD
  } state_t;

  localparam int CW = $clog2(DEAD_CYC + 1);

  logic [WIDTH-1:0] level [2];
  logic [1:0]       empty;
  logic [1:0]       full;

  assign level[0] = battA;
  assign level[1] = battB;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_level
      assign empty[gi] = (level[gi] <= WIDTH'(LOW_TH));
      assign full[gi]  = &level[gi];
    end
  endgenerate

  state_t          state_reg, state_next;
  logic            target_reg, target_next;  // 0 = A, 1 = B
  logic [CW-1:0]   dead_cnt_reg, dead_cnt_next;
  logic [7:0]      switch_cnt_reg, switch_cnt_next;
  logic            sel_a_reg, sel_b_reg, alarm_reg;
  logic            chg_a_reg, chg_b_reg;
  logic            chg_a_next, chg_b_next;
  logic            enter_dead;

  always_comb begin
    state_next      = state_reg;
    target_next     = target_reg;
    dead_cnt_next   = dead_cnt_reg;
    switch_cnt_next = switch_cnt_reg;
    enter_dead      = 1'b0;

    case (state_reg)
      ST_OFF: begin
        if (!empty[0])      state_next = ST_RUN_A;
        else if (!empty[1]) state_next = ST_RUN_B;
      end
      ST_RUN_A: begin
        if (empty[0]) begin
          if (!empty[1]) begin
            state_next  = ST_DEAD;
            target_next = 1'b1;
            enter_dead  = 1'b1;
          end else begin
            state_next = ST_OFF;
          end
        end
      end
      ST_RUN_B: begin
        if (empty[1]) begin
          if (!empty[0]) begin
            state_next  = ST_DEAD;
            target_next = 1'b0;
            enter_dead  = 1'b1;
          end else begin
            state_next = ST_OFF;
          end
        end
      end
      ST_DEAD: begin
        // The target is only judged at the end; the dead time always runs in full.
        if (dead_cnt_reg == CW'(DEAD_CYC)) begin
          if (empty[target_reg]) state_next = ST_OFF;
          else                   state_next = target_reg ? ST_RUN_B : ST_RUN_A;
        end else begin
          dead_cnt_next = dead_cnt_reg + CW'(1);
        end
      end
      default: state_next = ST_OFF;
    endcase

    if (enter_dead) begin
      dead_cnt_next = CW'(1);
      if (switch_cnt_reg != 8'hFF) switch_cnt_next = switch_cnt_reg + 8'd1;
    end
  end

  // Charger: released on any state change or on full; a grant needs an idle cycle.
  always_comb begin
    chg_a_next = 1'b0;
    chg_b_next = 1'b0;
    if ((state_next == state_reg) &&
        ((state_reg == ST_RUN_A) || (state_reg == ST_RUN_B))) begin
      if (chg_a_reg || chg_b_reg) begin
        chg_a_next = chg_a_reg & ~full[0];
        chg_b_next = chg_b_reg & ~full[1];
      end else if (state_reg == ST_RUN_A) begin
        chg_b_next = ~full[1];
      end else begin
        chg_a_next = ~full[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_OFF;
      target_reg     <= 1'b0;
      dead_cnt_reg   <= '0;
      switch_cnt_reg <= 8'd0;
      sel_a_reg      <= 1'b0;
      sel_b_reg      <= 1'b0;
      alarm_reg      <= 1'b0;
      chg_a_reg      <= 1'b0;
      chg_b_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      target_reg     <= target_next;
      dead_cnt_reg   <= dead_cnt_next;
      switch_cnt_reg <= switch_cnt_next;
      sel_a_reg      <= (state_next == ST_RUN_A);
      sel_b_reg      <= (state_next == ST_RUN_B);
      alarm_reg      <= (state_next == ST_OFF);
      chg_a_reg      <= chg_a_next;
      chg_b_reg      <= chg_b_next;
    end
  end

  assign sel_a      = sel_a_reg;
  assign sel_b      = sel_b_reg;
  assign chg_a      = chg_a_reg;
  assign chg_b      = chg_b_reg;
  assign alarm      = alarm_reg;
  assign switch_cnt = switch_cnt_reg;

endmodule
